// File: rtl/display_scan_controller.sv
// Time-multiplexed 7-segment scanner: sign position plus NUM_DIGITS BCD digits,
// frame-aligned value updates, leading-zero blanking and invalid-digit flagging.
module display_scan_controller #(
  parameter int NUM_DIGITS  = 3,
  parameter int NUM_AN      = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] input_bcd,
  input  logic [4*NUM_DIGITS-1:0] alu_bcd,
  input  logic                    input_sign,
  input  logic                    alu_sign,
  input  logic                    result_sel,
  input  logic                    blank_lz,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic [NUM_AN-1:0]       AN,
  output logic                    frame_tick,
  output logic                    bcd_err
);

  localparam int PS_W  = $clog2(REFRESH_DIV);
  localparam int POS_W = $clog2(NUM_DIGITS + 1);
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(REFRESH_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_DIGITS);

  // 7448-style decode; codes 10-15 are shown blank and flagged separately.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  logic [PS_W-1:0]         prescaler_reg, prescaler_next;
  logic [POS_W-1:0]        pos_reg, pos_next;
  logic [4*NUM_DIGITS-1:0] pending_bcd_reg, pending_bcd_next;
  logic                    pending_sign_reg, pending_sign_next;
  logic                    pending_blank_reg, pending_blank_next;
  logic                    pending_valid_reg, pending_valid_next;
  logic [4*NUM_DIGITS-1:0] active_bcd_reg, active_bcd_next;
  logic                    active_sign_reg, active_sign_next;
  logic                    active_blank_reg, active_blank_next;
  logic [6:0]              seg_reg, seg_next;
  logic [NUM_AN-1:0]       an_reg, an_next;
  logic                    frame_tick_reg;
  logic                    bcd_err_reg, bcd_err_next;

  logic                    at_terminal;
  logic                    frame_boundary;
  logic [4*NUM_DIGITS-1:0] load_bcd;
  logic                    load_sign;

  assign at_terminal    = (prescaler_reg == PS_LAST);
  assign frame_boundary = at_terminal && (pos_reg == POS_LAST);
  assign load_bcd       = result_sel ? alu_bcd : input_bcd;
  assign load_sign      = result_sel ? alu_sign : input_sign;

  always_comb begin
    prescaler_next = prescaler_reg + 1'b1;
    pos_next       = pos_reg;
    if (at_terminal) begin
      prescaler_next = '0;
      pos_next       = (pos_reg == POS_LAST) ? '0 : pos_reg + 1'b1;
    end
  end

  // Loads park in pending and land on the frame boundary, so a frame is
  // always drawn from one value; a load on the boundary itself goes straight in.
  always_comb begin
    pending_bcd_next   = pending_bcd_reg;
    pending_sign_next  = pending_sign_reg;
    pending_blank_next = pending_blank_reg;
    pending_valid_next = pending_valid_reg;
    active_bcd_next    = active_bcd_reg;
    active_sign_next   = active_sign_reg;
    active_blank_next  = active_blank_reg;
    if (load && frame_boundary) begin
      active_bcd_next    = load_bcd;
      active_sign_next   = load_sign;
      active_blank_next  = blank_lz;
      pending_valid_next = 1'b0;
    end else if (load) begin
      pending_bcd_next   = load_bcd;
      pending_sign_next  = load_sign;
      pending_blank_next = blank_lz;
      pending_valid_next = 1'b1;
    end else if (frame_boundary && pending_valid_reg) begin
      active_bcd_next    = pending_bcd_reg;
      active_sign_next   = pending_sign_reg;
      active_blank_next  = pending_blank_reg;
      pending_valid_next = 1'b0;
    end
  end

  // Per-digit view of the active value; nibble index 0 is the LSD.
  logic [NUM_DIGITS-1:0] nib_zero;
  logic [NUM_DIGITS-1:0] nib_bad;
  logic [NUM_DIGITS-1:0] lead_zero;
  logic [6:0]            digit_seg [NUM_DIGITS];
  logic [6:0]            sign_seg;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] nibble;
      assign nibble       = active_bcd_reg[4*gi +: 4];
      assign nib_zero[gi] = (nibble == 4'd0);
      assign nib_bad[gi]  = (nibble > 4'd9);
      if (gi == 0) begin : g_lsd
        assign digit_seg[gi] = bcd_to_seg(nibble);
      end else begin : g_upper
        assign digit_seg[gi] = (active_blank_reg && lead_zero[gi]) ? 7'b0000000
                                                                   : bcd_to_seg(nibble);
      end
    end
  endgenerate

  // lead_zero[i]: nibble i and every more significant nibble are zero.
  always_comb begin
    logic zero_run;
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run & nib_zero[i];
      lead_zero[i] = zero_run;
    end
  end

  assign sign_seg     = (active_sign_reg && (|active_bcd_reg)) ? 7'b0000001 : 7'b0000000;
  assign bcd_err_next = |nib_bad;

  always_comb begin
    seg_next = 7'b0000000;
    if (pos_reg == '0) begin
      seg_next = sign_seg;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (pos_reg == POS_W'(NUM_DIGITS - i)) seg_next = digit_seg[i];
      end
    end
  end

  // Anode NUM_DIGITS is the sign position, anode 0 the LSD; spare anodes stay off.
  generate
    for (genvar gi = 0; gi < NUM_AN; gi++) begin : g_anode
      if (gi <= NUM_DIGITS) begin : g_used
        assign an_next[gi] = (pos_reg == POS_W'(NUM_DIGITS - gi));
      end else begin : g_unused
        assign an_next[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler_reg     <= '0;
      pos_reg           <= '0;
      pending_bcd_reg   <= '0;
      pending_sign_reg  <= 1'b0;
      pending_blank_reg <= 1'b0;
      pending_valid_reg <= 1'b0;
      active_bcd_reg    <= '0;
      active_sign_reg   <= 1'b0;
      active_blank_reg  <= 1'b0;
      seg_reg           <= 7'b0000000;
      an_reg            <= '0;
      frame_tick_reg    <= 1'b0;
      bcd_err_reg       <= 1'b0;
    end else begin
      prescaler_reg     <= prescaler_next;
      pos_reg           <= pos_next;
      pending_bcd_reg   <= pending_bcd_next;
      pending_sign_reg  <= pending_sign_next;
      pending_blank_reg <= pending_blank_next;
      pending_valid_reg <= pending_valid_next;
      active_bcd_reg    <= active_bcd_next;
      active_sign_reg   <= active_sign_next;
      active_blank_reg  <= active_blank_next;
      seg_reg           <= seg_next;
      an_reg            <= an_next;
      frame_tick_reg    <= frame_boundary;
      bcd_err_reg       <= bcd_err_next;
    end
  end

  assign seg        = seg_reg;
  assign AN         = an_reg;
  assign frame_tick = frame_tick_reg;
  assign bcd_err    = bcd_err_reg;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with NUM_DIGITS=3, REFRESH_DIV=4
// (16-cycle frames); each task checks its own scenario against hand-derived codes.
module tb_display_scan_controller;

  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011;
  localparam logic [6:0] S6 = 7'b1011111, S7 = 7'b1110000, S8 = 7'b1111111;
  localparam logic [6:0] S9 = 7'b1111011, MN = 7'b0000001, BL = 7'b0000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] input_bcd = 12'h000;
  logic [11:0] alu_bcd = 12'h000;
  logic        input_sign = 1'b0;
  logic        alu_sign = 1'b0;
  logic        result_sel = 1'b0;
  logic        blank_lz = 1'b0;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic [7:0]  AN;
  logic        frame_tick;
  logic        bcd_err;

  int total = 0;
  int passed = 0;

  logic [6:0] seg_cap [16];
  logic [7:0] an_cap [16];
  logic       ft_cap [16];
  logic [6:0] exp_seg [4];
  bit         timed_out;

  display_scan_controller #(
    .NUM_DIGITS(3),
    .NUM_AN(8),
    .REFRESH_DIV(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .input_bcd(input_bcd),
    .alu_bcd(alu_bcd),
    .input_sign(input_sign),
    .alu_sign(alu_sign),
    .result_sel(result_sel),
    .blank_lz(blank_lz),
    .load(load),
    .seg(seg),
    .AN(AN),
    .frame_tick(frame_tick),
    .bcd_err(bcd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // The unselected source gets inverted data so a wrong mux choice shows up.
  task automatic do_load(input logic sel, input logic [11:0] bcd, input logic sgn,
                         input logic blz);
    result_sel = sel;
    blank_lz   = blz;
    alu_bcd    = sel ? bcd : ~bcd;
    input_bcd  = sel ? ~bcd : bcd;
    alu_sign   = sel ? sgn : ~sgn;
    input_sign = sel ? ~sgn : sgn;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic wait_tick(output bit to);
    int n = 0;
    do begin
      step();
      n++;
    end while (frame_tick !== 1'b1 && n < 40);
    to = (frame_tick !== 1'b1);
  endtask

  task automatic capture_frame();
    for (int k = 0; k < 16; k++) begin
      step();
      seg_cap[k] = seg;
      an_cap[k]  = AN;
      ft_cap[k]  = frame_tick;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (seg !== 7'b0 || AN !== 8'b0)
        $display("FAIL reset_hold cyc=%0d got seg=%b AN=%b want 0/0", i, seg, AN);
      else passed++;
    end
    reset = 1'b0;
    step();
    total++;
    if (AN !== 8'b00001000) $display("FAIL reset_first_an got=%b want=00001000", AN);
    else passed++;
    total++;
    if (seg !== BL || frame_tick !== 1'b0 || bcd_err !== 1'b0)
      $display("FAIL reset_first_out got seg=%b ft=%b err=%b want 0", seg, frame_tick, bcd_err);
    else passed++;
  endtask

  task automatic test_alu_value();
    logic [7:0] exp_an;
    do_load(1'b1, 12'h123, 1'b1, 1'b0);
    wait_tick(timed_out);
    total++;
    if (timed_out) $display("FAIL alu_tick got=timeout want=tick");
    else passed++;
    capture_frame();
    exp_seg = '{MN, S1, S2, S3};
    for (int k = 0; k < 16; k++) begin
      exp_an = 8'b1 << (3 - k / 4);
      total++;
      if (seg_cap[k] !== exp_seg[k/4] || an_cap[k] !== exp_an)
        $display("FAIL alu_scan k=%0d got seg=%b AN=%b want seg=%b AN=%b",
                 k, seg_cap[k], an_cap[k], exp_seg[k/4], exp_an);
      else passed++;
      total++;
      if (ft_cap[k] !== (k == 15))
        $display("FAIL alu_frame_tick k=%0d got=%b want=%b", k, ft_cap[k], (k == 15));
      else passed++;
    end
  endtask

  task automatic test_leading_zero();
    logic [11:0] bcds [5];
    logic        blzs [5];
    logic [6:0]  tbl [5][4];
    bcds = '{12'h007, 12'h007, 12'h070, 12'h000, 12'h100};
    blzs = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl  = '{'{BL, BL, BL, S7}, '{BL, S0, S0, S7}, '{BL, BL, S7, S0},
             '{BL, BL, BL, S0}, '{BL, S1, S0, S0}};
    for (int c = 0; c < 5; c++) begin
      do_load(1'b0, bcds[c], 1'b0, blzs[c]);
      wait_tick(timed_out);
      total++;
      if (timed_out) $display("FAIL lz_tick case=%0d got=timeout want=tick", c);
      else passed++;
      capture_frame();
      for (int k = 0; k < 16; k++) begin
        total++;
        if (seg_cap[k] !== tbl[c][k/4])
          $display("FAIL lz_seg case=%0d k=%0d got=%b want=%b", c, k, seg_cap[k], tbl[c][k/4]);
        else passed++;
      end
    end
  endtask

  task automatic test_bcd_err();
    do_load(1'b1, 12'h0A5, 1'b0, 1'b0);
    total++;
    if (bcd_err !== 1'b0) $display("FAIL err_before_boundary got=%b want=0", bcd_err);
    else passed++;
    wait_tick(timed_out);
    total++;
    if (timed_out) $display("FAIL err_tick got=timeout want=tick");
    else passed++;
    capture_frame();
    exp_seg = '{BL, S0, BL, S5};
    for (int k = 0; k < 16; k++) begin
      total++;
      if (seg_cap[k] !== exp_seg[k/4])
        $display("FAIL err_seg k=%0d got=%b want=%b", k, seg_cap[k], exp_seg[k/4]);
      else passed++;
    end
    total++;
    if (bcd_err !== 1'b1) $display("FAIL err_set got=%b want=1", bcd_err);
    else passed++;
    do_load(1'b1, 12'h000, 1'b1, 1'b1);
    total++;
    if (bcd_err !== 1'b1) $display("FAIL err_held_mid_frame got=%b want=1", bcd_err);
    else passed++;
    wait_tick(timed_out);
    capture_frame();
    exp_seg = '{BL, BL, BL, S0};
    for (int k = 0; k < 16; k++) begin
      total++;
      if (seg_cap[k] !== exp_seg[k/4])
        $display("FAIL neg_zero_seg k=%0d got=%b want=%b", k, seg_cap[k], exp_seg[k/4]);
      else passed++;
    end
    total++;
    if (bcd_err !== 1'b0) $display("FAIL err_clear got=%b want=0", bcd_err);
    else passed++;
  endtask

  task automatic test_mid_frame();
    logic [6:0] want;
    do_load(1'b1, 12'h123, 1'b1, 1'b0);
    wait_tick(timed_out);
    repeat (8) step();
    do_load(1'b1, 12'h456, 1'b0, 1'b0);
    for (int j = 0; j < 8; j++) begin
      if (j > 0) step();
      want = (j < 4) ? S2 : S3;
      total++;
      if (seg !== want) $display("FAIL mid_hold j=%0d got=%b want=%b", j, seg, want);
      else passed++;
    end
    total++;
    if (frame_tick !== 1'b1) $display("FAIL mid_tick got=%b want=1", frame_tick);
    else passed++;
    capture_frame();
    exp_seg = '{BL, S4, S5, S6};
    for (int k = 0; k < 16; k++) begin
      total++;
      if (seg_cap[k] !== exp_seg[k/4])
        $display("FAIL mid_new k=%0d got=%b want=%b", k, seg_cap[k], exp_seg[k/4]);
      else passed++;
    end
  endtask

  task automatic test_boundary_load();
    repeat (15) step();
    do_load(1'b1, 12'h789, 1'b1, 1'b0);
    total++;
    if (frame_tick !== 1'b1) $display("FAIL bnd_tick got=%b want=1", frame_tick);
    else passed++;
    capture_frame();
    exp_seg = '{MN, S7, S8, S9};
    for (int k = 0; k < 16; k++) begin
      total++;
      if (seg_cap[k] !== exp_seg[k/4])
        $display("FAIL bnd_seg k=%0d got=%b want=%b", k, seg_cap[k], exp_seg[k/4]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    do_load(1'b1, 12'h321, 1'b1, 1'b0);
    do_load(1'b0, 12'h654, 1'b0, 1'b0);
    wait_tick(timed_out);
    total++;
    if (timed_out) $display("FAIL b2b_tick got=timeout want=tick");
    else passed++;
    capture_frame();
    exp_seg = '{BL, S6, S5, S4};
    for (int k = 0; k < 16; k++) begin
      total++;
      if (seg_cap[k] !== exp_seg[k/4])
        $display("FAIL b2b_seg k=%0d got=%b want=%b", k, seg_cap[k], exp_seg[k/4]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_frame();
    do_load(1'b1, 12'h111, 1'b1, 1'b1);
    repeat (8) step();
    reset = 1'b1;
    step();
    total++;
    if (seg !== 7'b0 || AN !== 8'b0 || frame_tick !== 1'b0 || bcd_err !== 1'b0)
      $display("FAIL rst_mid_outs got seg=%b AN=%b ft=%b err=%b want all 0",
               seg, AN, frame_tick, bcd_err);
    else passed++;
    reset = 1'b0;
    step();
    total++;
    if (AN !== 8'b00001000 || seg !== BL)
      $display("FAIL rst_mid_restart got seg=%b AN=%b want seg=0000000 AN=00001000", seg, AN);
    else passed++;
    repeat (14) step();
    total++;
    if (frame_tick !== 1'b0) $display("FAIL rst_mid_early_tick got=%b want=0", frame_tick);
    else passed++;
    step();
    total++;
    if (frame_tick !== 1'b1) $display("FAIL rst_mid_tick got=%b want=1", frame_tick);
    else passed++;
    capture_frame();
    exp_seg = '{BL, S0, S0, S0};
    for (int k = 0; k < 16; k++) begin
      total++;
      if (seg_cap[k] !== exp_seg[k/4])
        $display("FAIL rst_mid_cleared k=%0d got=%b want=%b", k, seg_cap[k], exp_seg[k/4]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_alu_value();
    test_leading_zero();
    test_bcd_err();
    test_mid_frame();
    test_boundary_load();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
